// File: rtl/wait_event.sv
// WAIT command stage: waits for a named watched signal to reach an edge or level condition,
// with an optional cycle budget, then pulses o_done.
module wait_event #(
  parameter int unsigned WAIT_SIZE     = 5,
  parameter int unsigned TIMEOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  string                    i_wait_alias [WAIT_SIZE],
  input  logic [WAIT_SIZE-1:0]     i_wait_signals,
  input  logic                     i_sel_wait,
  input  logic                     i_args_valid,
  input  string                    i_args [5],
  output logic                     o_done,
  output logic                     o_timeout,
  output logic [15:0]              o_err_cnt,
  output logic                     o_busy
);

  localparam int unsigned IdxW = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StWait, StDone} state_e;
  typedef enum logic [1:0] {CondRise, CondFall, CondHigh, CondLow} cond_e;

  state_e                   state_q, state_d;
  cond_e                    cond_q, cond_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     prev_q, prev_d;
  logic                     timeout_q, timeout_d;
  logic [15:0]              err_q, err_d;

  // Argument decode, evaluated combinationally on the acceptance cycle only.
  logic                     alias_found;
  logic [IdxW-1:0]          alias_idx;
  logic                     cond_ok;
  cond_e                    cond_code;
  logic                     num_ok;
  logic [TIMEOUT_WIDTH-1:0] num_val;
  logic [7:0]               ch;

  always_comb begin
    alias_found = 1'b0;
    alias_idx   = '0;
    // Scan downwards so the lowest matching index wins.
    for (int k = int'(WAIT_SIZE) - 1; k >= 0; k--) begin
      if (i_wait_alias[k] == i_args[1]) begin
        alias_found = 1'b1;
        alias_idx   = IdxW'(k);
      end
    end

    cond_ok   = 1'b1;
    cond_code = CondRise;
    if (i_args[2] == "RISE")      cond_code = CondRise;
    else if (i_args[2] == "FALL") cond_code = CondFall;
    else if (i_args[2] == "HIGH") cond_code = CondHigh;
    else if (i_args[2] == "LOW")  cond_code = CondLow;
    else                          cond_ok   = 1'b0;

    num_ok  = (i_args[3].len() > 0);
    num_val = '0;
    ch      = 8'd0;
    for (int c = 0; c < i_args[3].len(); c++) begin
      ch = i_args[3].getc(c);
      if (ch < 8'd48 || ch > 8'd57) begin
        num_ok = 1'b0;
      end else begin
        num_val = num_val * TIMEOUT_WIDTH'(10) + TIMEOUT_WIDTH'(ch - 8'd48);
      end
    end
  end

  logic        cur;
  logic        met;
  logic [15:0] err_inc;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;

  always_comb begin
    cur     = i_wait_signals[idx_q];
    cnt_inc = cnt_q + TIMEOUT_WIDTH'(1);
    err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    unique case (cond_q)
      CondRise: met = !prev_q && cur;
      CondFall: met = prev_q && !cur;
      CondHigh: met = cur;
      CondLow:  met = !cur;
      default:  met = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cond_q    <= CondRise;
      idx_q     <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cond_d    = cond_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_args_valid && i_sel_wait) begin
          timeout_d = 1'b0;
          idx_d     = alias_idx;
          cond_d    = cond_code;
          tmo_d     = num_val;
          if (alias_found && cond_ok && num_ok) begin
            state_d = StArm;
          end else begin
            state_d = StDone;
            err_d   = err_inc;
          end
        end
      end
      StArm: begin
        prev_d  = cur;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        prev_d = cur;
        cnt_d  = cnt_inc;
        // A met condition takes priority over a coincident timeout.
        if (met) begin
          state_d = StDone;
        end else if (tmo_q != '0 && cnt_inc == tmo_q) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          err_d     = err_inc;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_done    = (state_q == StDone);
    o_busy    = (state_q == StArm) || (state_q == StWait);
    o_timeout = timeout_q;
    o_err_cnt = err_q;
  end

endmodule

// File: tb/tb_wait_event.sv
// Directed bench for wait_event: latency, timeout, bad arguments and reset behaviour.
module tb_wait_event;

  logic        clk;
  logic        rst_n;
  string       wait_alias [5];
  logic [4:0]  wait_signals;
  logic        sel_wait;
  logic        args_valid;
  string       args [5];
  logic        done;
  logic        timeout;
  logic [15:0] err_cnt;
  logic        busy;

  int checks;
  int failures;
  int lat;
  int cnt;

  wait_event #(
    .WAIT_SIZE    (5),
    .TIMEOUT_WIDTH(32)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wait_alias  (wait_alias),
    .i_wait_signals(wait_signals),
    .i_sel_wait    (sel_wait),
    .i_args_valid  (args_valid),
    .i_args        (args),
    .o_done        (done),
    .o_timeout     (timeout),
    .o_err_cnt     (err_cnt),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_args(input string a1, input string a2, input string a3);
    args[0] = "WAIT";
    args[1] = a1;
    args[2] = a2;
    args[3] = a3;
    args[4] = "";
  endtask

  // Present a command for one edge; returns one tick past the acceptance edge.
  task automatic send(input string a1, input string a2, input string a3);
    set_args(a1, a2, a3);
    args_valid = 1'b1;
    sel_wait   = 1'b1;
    tick();
    args_valid = 1'b0;
  endtask

  // Ticks until o_done, starting from count n; budget-limited.
  task automatic wait_done(input int n, output int l);
    l = n;
    while (!done && l < 200) begin
      tick();
      l++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done && busy) check_eq("done_busy_excl", 32'(done & busy), 32'd0);
  end

  initial begin
    checks       = 0;
    failures     = 0;
    wait_alias   = '{"I0", "I1", "I2", "I3", "I4"};
    wait_signals = 5'b00000;
    sel_wait     = 1'b0;
    args_valid   = 1'b0;
    set_args("I0", "HIGH", "0");
    rst_n        = 1'b0;

    // Reset with command pulses present.
    for (int i = 0; i < 3; i++) begin
      args_valid = (i != 1);
      sel_wait   = 1'b1;
      tick();
    end
    args_valid = 1'b0;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    check_eq("rst_no_done", 32'(cnt), 32'd0);

    // Valid without select is not a command.
    set_args("I0", "LOW", "0");
    args_valid = 1'b1;
    sel_wait   = 1'b0;
    tick();
    args_valid = 1'b0;
    tick();
    check_eq("nosel_busy", 32'(busy), 32'd0);

    // RISE on I2 at the 5th WAIT cycle.
    send("I2", "RISE", "100");
    check_eq("rise_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    wait_signals[2] = 1'b1;
    wait_done(6, lat);
    check_eq("rise_lat", 32'(lat), 32'd7);
    check_eq("rise_timeout", 32'(timeout), 32'd0);
    tick();
    check_eq("rise_err", 32'(err_cnt), 32'd0);

    // HIGH already true.
    wait_signals[0] = 1'b1;
    send("I0", "HIGH", "0");
    wait_done(1, lat);
    check_eq("high_lat", 32'(lat), 32'd3);
    tick();

    // FALL never happens: timeout after 10 WAIT cycles.
    wait_signals[1] = 1'b1;
    send("I1", "FALL", "10");
    wait_done(1, lat);
    check_eq("tmo_lat", 32'(lat), 32'd12);
    check_eq("tmo_flag", 32'(timeout), 32'd1);
    tick();
    check_eq("tmo_err", 32'(err_cnt), 32'd1);
    repeat (2) tick();
    check_eq("tmo_held", 32'(timeout), 32'd1);
    send("I0", "HIGH", "0");
    check_eq("tmo_cleared", 32'(timeout), 32'd0);
    wait_done(1, lat);
    check_eq("high2_lat", 32'(lat), 32'd3);
    tick();

    // Bad alias, bad condition, bad timeout.
    send("I9", "HIGH", "5");
    wait_done(1, lat);
    check_eq("badalias_lat", 32'(lat), 32'd1);
    check_eq("badalias_timeout", 32'(timeout), 32'd0);
    tick();
    check_eq("badalias_err", 32'(err_cnt), 32'd2);
    send("I0", "EDGE", "5");
    wait_done(1, lat);
    check_eq("badcond_lat", 32'(lat), 32'd1);
    tick();
    check_eq("badcond_err", 32'(err_cnt), 32'd3);
    send("I0", "HIGH", "1x");
    wait_done(1, lat);
    check_eq("badnum_lat", 32'(lat), 32'd1);
    tick();
    check_eq("badnum_err", 32'(err_cnt), 32'd4);

    // Reset during WAIT abandons the wait.
    wait_signals[3] = 1'b0;
    send("I3", "HIGH", "0");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_err", 32'(err_cnt), 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) cnt++;
      tick();
    end
    check_eq("midrst_no_done", 32'(cnt), 32'd0);

    // Command while busy is dropped; fresh RISE completes.
    send("I3", "RISE", "50");
    tick();
    set_args("I9", "HIGH", "5");
    args_valid = 1'b1;
    sel_wait   = 1'b1;
    tick();
    args_valid = 1'b0;
    wait_signals[3] = 1'b1;
    wait_done(3, lat);
    check_eq("fresh_lat", 32'(lat), 32'd4);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) cnt++;
    end
    check_eq("ignored_no_done", 32'(cnt), 32'd0);
    check_eq("ignored_err", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wait_event.md
Name: wait_event

Overview:
- Testbench command stage directly downstream of the decoder, selected by the decoder's wait-select output.
- Services WAIT commands from the sequencer: it waits for a named DUT signal to reach a condition (rising edge, falling edge, high level or low level) within a cycle budget.
- On completion it returns a one-cycle done pulse, from which the decoder acknowledges the sequencer, plus a timeout flag and an error count.

Parameters:
- WAIT_SIZE, 5, number of watchable 1-bit signals and number of entries in the alias table.
- TIMEOUT_WIDTH, 32, width of the timeout counter and of the parsed timeout argument.

Ports:
- clk  input  1  testbench clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- i_wait_alias  input  string[WAIT_SIZE]  alias name of each watched signal; index k names i_wait_signals[k].
- i_wait_signals  input  WAIT_SIZE  watched DUT signals, sampled on rising clk.
- i_sel_wait  input  1  decoder select: the current command is a WAIT.
- i_args_valid  input  1  command arguments valid (1-cycle pulse from the sequencer).
- i_args  input  string[5]  [0]="WAIT", [1]=alias, [2]="RISE"/"FALL"/"HIGH"/"LOW", [3]=timeout in cycles as a decimal string ("0" = no timeout), [4] unused.
- o_done  output  1  one-cycle pulse when the wait has completed (met, timed out or error).
- o_timeout  output  1  set on the o_done pulse of a timed-out wait; held until the next accepted command.
- o_err_cnt  output  16  count of timeouts plus bad-argument commands; saturates at 0xFFFF.
- o_busy  output  1  high from the cycle after acceptance until o_done.

Behaviour:
- Reset (rst_n=0 at a rising clk):
  - State goes to IDLE.
  - o_done=0, o_timeout=0, o_err_cnt=0, o_busy=0, timeout counter=0, edge-sample register=0.
  - Applies mid-wait too: the wait is abandoned and no o_done is produced.
- Acceptance:
  - A command is accepted only in IDLE, at a rising clk where i_args_valid=1 and i_sel_wait=1.
  - At acceptance, latch the alias index (first k where i_wait_alias[k]==i_args[1]), the condition code, and the timeout parsed from i_args[3].
  - At acceptance, clear o_timeout.
  - i_args_valid while not IDLE is ignored; it does not queue.
- Bad arguments (alias not found, condition string not one of the four, or timeout string non-numeric):
  - Go to DONE.
  - o_done pulses on the cycle after acceptance.
  - o_err_cnt increments by 1.
  - o_timeout=0.
- States: IDLE -> ARM -> WAIT -> DONE -> IDLE.
  - ARM, one cycle: load prev <= i_wait_signals[idx] and counter <= 0. The condition is not evaluated.
  - WAIT, each cycle: cur = i_wait_signals[idx].
    - Met condition: RISE is prev=0 & cur=1; FALL is prev=1 & cur=0; HIGH is cur=1; LOW is cur=0.
    - Then prev <= cur and counter <= counter+1.
    - Met -> DONE.
    - Else if timeout≠0 and counter+1 == timeout -> DONE with the timeout flag set.
    - Met and timeout hit in the same cycle: met wins; o_timeout=0 and no error increment.
  - DONE, one cycle: o_done=1; o_timeout=flag; o_err_cnt += flag (saturating); then IDLE.
- Latency:
  - A level condition already true at acceptance: o_done is high 3 cycles after the acceptance edge (ARM, WAIT, DONE).
  - An edge occurring at WAIT cycle n: o_done is high n+1 cycles after entering WAIT.
  - Timeout T: o_done is high T+2 cycles after acceptance (ARM, T WAIT cycles, DONE).
- Counter:
  - The counter wraps mod 2^TIMEOUT_WIDTH.
  - With timeout=0, the wait is unbounded and the counter wrap is harmless.
- o_busy = (state ARM or WAIT).
- o_done and o_busy are never high together.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with i_args_valid pulsing -> all outputs 0; no o_done for 10 cycles after release.
- RISE: args {"WAIT","I2","RISE","100"}; drive signal 2 from 0 to 1 at the 5th WAIT cycle -> o_done on the 6th WAIT-relative cycle; o_timeout=0; o_err_cnt=0.
- HIGH already true: signal 0 held at 1; args {"WAIT","I0","HIGH","0"} -> o_done exactly 3 cycles after acceptance.
- Timeout: args {"WAIT","I1","FALL","10"}; signal 1 held at 1 -> o_done 12 cycles after acceptance; o_timeout=1; o_err_cnt=1. The next accepted command clears o_timeout.
- Bad alias: args {"WAIT","I9","HIGH","5"} -> o_done 1 cycle after acceptance; o_err_cnt increments; o_timeout=0. Repeat with condition "EDGE" -> same response.
- Reset mid-wait, plus ignored command: assert rst_n=0 during WAIT -> no o_done and state IDLE. After release, an i_args_valid pulse while busy is ignored, and a fresh command completes normally.
